// File: rtl/dc_axi_read_arbiter_if.sv
// AXI read-channel bundle (AR + R) shared between the read arbiter and the external port.
interface dc_axi_read_arbiter_if #(
  parameter int unsigned AXI_ARADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH   = 16
);
  logic [7:0]                  arid;
  logic [AXI_ARADDR_WIDTH-1:0] araddr;
  logic [7:0]                  arlen;
  logic [2:0]                  arsize;
  logic [1:0]                  arburst;
  logic                        arvalid;
  logic                        arready;
  logic [7:0]                  rid;
  logic [AXI_DATA_WIDTH-1:0]   rdata;
  logic                        rlast;
  logic                        rvalid;
  logic                        rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rlast, rvalid,
    output rready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/dc_axi_read_arbiter.sv
// Round-robin AXI read front-end: NUM_CH fetch channels share one AR/R port,
// bursts are tagged with ARID = channel index and R beats are routed back by RID.
module dc_axi_read_arbiter #(
  parameter int unsigned NUM_CH           = 4,
  parameter int unsigned AXI_ARADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH   = 16,
  parameter int unsigned MAX_OUTSTANDING  = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 en_i,
  input  logic [NUM_CH-1:0]                    ch_arvalid_i,
  output logic [NUM_CH-1:0]                    ch_arready_o,
  input  logic [NUM_CH*AXI_ARADDR_WIDTH-1:0]   ch_araddr_i,
  input  logic [NUM_CH*8-1:0]                  ch_arlen_i,
  output logic [NUM_CH-1:0]                    ch_rvalid_o,
  input  logic [NUM_CH-1:0]                    ch_rready_i,
  output logic [AXI_DATA_WIDTH-1:0]            ch_rdata_o,
  output logic                                 ch_rlast_o,
  output logic                                 err_id_o,
  dc_axi_read_arbiter_if.master                axi_io
);

  localparam int unsigned IdxW = $clog2(NUM_CH);
  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CntW-1:0] MaxOut  = CntW'(MAX_OUTSTANDING);
  localparam logic [7:0]      NumChId = 8'(NUM_CH);
  localparam logic [IdxW-1:0] LastCh  = IdxW'(NUM_CH - 1);

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  state_e                      state_q, state_d;
  logic [IdxW-1:0]             rr_ptr_q, rr_ptr_d;
  logic [AXI_ARADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [7:0]                  arlen_q, arlen_d;
  logic [7:0]                  arid_q, arid_d;
  logic                        arvalid_q, arvalid_d;
  logic [CntW-1:0]             cnt_q [NUM_CH];
  logic [CntW-1:0]             cnt_d [NUM_CH];
  logic                        err_q, err_d;

  logic [NUM_CH-1:0] eligible;
  logic              grant_vld;
  logic [IdxW-1:0]   grant_idx;
  logic [IdxW-1:0]   cand;
  logic              ar_hs;
  logic              rid_hit;
  logic [IdxW-1:0]   rid_idx;
  logic              rready;
  logic              r_last_hs;
  logic              inc, dec;

  // Arbitration eligibility: requesting, enabled and below the outstanding cap.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      eligible[i] = en_i && ch_arvalid_i[i] && (cnt_q[i] < MaxOut);
    end
  end

  // Scan rr_ptr+1, rr_ptr+2, ... so the last served channel has lowest priority.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      cand = IdxW'((32'(rr_ptr_q) + k) % NUM_CH);
      if (!grant_vld && eligible[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign ar_hs = (state_q == StIssue) && axi_io.arready;

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;
    arid_d       = arid_q;
    arvalid_d    = arvalid_q;
    ch_arready_o = '0;
    unique case (state_q)
      StIdle: begin
        if (grant_vld) begin
          ch_arready_o[grant_idx] = 1'b1;
          araddr_d  = ch_araddr_i[32'(grant_idx)*AXI_ARADDR_WIDTH +: AXI_ARADDR_WIDTH];
          arlen_d   = ch_arlen_i[32'(grant_idx)*8 +: 8];
          arid_d    = 8'(grant_idx);
          arvalid_d = 1'b1;
          state_d   = StIssue;
        end
      end
      StIssue: begin
        // en_i is ignored here: a presented AR must stay valid until accepted.
        if (axi_io.arready) begin
          arvalid_d = 1'b0;
          rr_ptr_d  = arid_q[IdxW-1:0];
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // R routing is purely combinational and independent of en_i.
  assign rid_hit = axi_io.rid < NumChId;
  assign rid_idx = axi_io.rid[IdxW-1:0];
  assign rready  = rid_hit ? ch_rready_i[rid_idx] : 1'b1;

  always_comb begin
    ch_rvalid_o = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      ch_rvalid_o[i] = axi_io.rvalid && rid_hit && (axi_io.rid == 8'(i));
    end
  end

  assign r_last_hs = axi_io.rvalid && rready && axi_io.rlast;

  // Outstanding tracking; a simultaneous issue and completion cancel out.
  always_comb begin
    err_d = err_q;
    inc   = 1'b0;
    dec   = 1'b0;
    if (axi_io.rvalid && !rid_hit) begin
      err_d = 1'b1;
    end
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      inc      = ar_hs && (arid_q == 8'(i));
      dec      = r_last_hs && rid_hit && (axi_io.rid == 8'(i));
      cnt_d[i] = cnt_q[i];
      if (inc && !dec) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (dec && !inc) begin
        if (cnt_q[i] == '0) begin
          err_d = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      rr_ptr_q  <= LastCh;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arid_q    <= '0;
      arvalid_q <= 1'b0;
      err_q     <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arid_q    <= arid_d;
      arvalid_q <= arvalid_d;
      err_q     <= err_d;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign axi_io.arid    = arid_q;
  assign axi_io.araddr  = araddr_q;
  assign axi_io.arlen   = arlen_q;
  assign axi_io.arsize  = 3'($clog2(AXI_DATA_WIDTH / 8));
  assign axi_io.arburst = 2'b01;
  assign axi_io.arvalid = arvalid_q;
  assign axi_io.rready  = rready;

  assign ch_rdata_o = axi_io.rdata;
  assign ch_rlast_o = axi_io.rlast;
  assign err_id_o   = err_q;

endmodule

// File: tb/tb_dc_axi_read_arbiter.sv
// Directed bench for dc_axi_read_arbiter: 4 channels, 32-bit address, 16-bit data, 2 outstanding.
module tb_dc_axi_read_arbiter;

  localparam int unsigned NCh = 4;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [NCh-1:0]    ch_arvalid;
  logic [NCh-1:0]    ch_arready;
  logic [NCh*AW-1:0] ch_araddr;
  logic [NCh*8-1:0]  ch_arlen;
  logic [NCh-1:0]    ch_rvalid;
  logic [NCh-1:0]    ch_rready;
  logic [DW-1:0]     ch_rdata;
  logic              ch_rlast;
  logic              err_id;

  int n_checks = 0;
  int n_fail   = 0;

  dc_axi_read_arbiter_if #(.AXI_ARADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) axi_bus ();

  dc_axi_read_arbiter #(
    .NUM_CH          (NCh),
    .AXI_ARADDR_WIDTH(AW),
    .AXI_DATA_WIDTH  (DW),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en_i        (en),
    .ch_arvalid_i(ch_arvalid),
    .ch_arready_o(ch_arready),
    .ch_araddr_i (ch_araddr),
    .ch_arlen_i  (ch_arlen),
    .ch_rvalid_o (ch_rvalid),
    .ch_rready_i (ch_rready),
    .ch_rdata_o  (ch_rdata),
    .ch_rlast_o  (ch_rlast),
    .err_id_o    (err_id),
    .axi_io      (axi_bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  int order [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst = 1'b1; en = 1'b0; ch_arvalid = '0; ch_araddr = '0; ch_arlen = '0; ch_rready = 4'hF;
    axi_bus.arready = 1'b0; axi_bus.rid = '0; axi_bus.rdata = '0;
    axi_bus.rlast = 1'b0; axi_bus.rvalid = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    mid();
    check_eq("rst_arvalid", 64'(axi_bus.arvalid), 64'd0);
    check_eq("rst_arid", 64'(axi_bus.arid), 64'd0);
    check_eq("rst_araddr", 64'(axi_bus.araddr), 64'd0);
    check_eq("rst_arlen", 64'(axi_bus.arlen), 64'd0);
    check_eq("rst_ch_arready", 64'(ch_arready), 64'd0);
    check_eq("rst_err", 64'(err_id), 64'd0);
    cyc();
    rst = 1'b0;

    // Single request on channel 0
    en = 1'b1; ch_arvalid = 4'b0001; ch_araddr[31:0] = 32'h1000; ch_arlen[7:0] = 8'd7;
    axi_bus.arready = 1'b1;
    mid();
    check_eq("t1_ch_arready", 64'(ch_arready), 64'h1);
    check_eq("t1_arvalid_lat", 64'(axi_bus.arvalid), 64'd0);
    cyc();
    ch_arvalid = '0;
    mid();
    check_eq("t1_arvalid", 64'(axi_bus.arvalid), 64'd1);
    check_eq("t1_araddr", 64'(axi_bus.araddr), 64'h1000);
    check_eq("t1_arlen", 64'(axi_bus.arlen), 64'd7);
    check_eq("t1_arid", 64'(axi_bus.arid), 64'd0);
    check_eq("t1_arsize", 64'(axi_bus.arsize), 64'd1);
    check_eq("t1_arburst", 64'(axi_bus.arburst), 64'd1);
    check_eq("t1_ch_arready_issue", 64'(ch_arready), 64'd0);
    cyc();
    mid();
    check_eq("t1_arvalid_drop", 64'(axi_bus.arvalid), 64'd0);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;

    // All channels request: round-robin 0,1,2,3,0 with one AR per 2 cycles
    for (int i = 0; i < 4; i++) begin
      ch_araddr[i*32 +: 32] = 32'h2000 + 32'(i) * 32'h100;
      ch_arlen[i*8 +: 8]    = 8'(i + 1);
    end
    ch_arvalid = 4'hF;
    for (int g = 0; g < 5; g++) begin
      if (g > 0) begin
        axi_bus.rvalid = 1'b1; axi_bus.rid = 8'(order[g-1]); axi_bus.rlast = 1'b1;
      end
      mid();
      check_eq($sformatf("t2_grant%0d", g), 64'(ch_arready), 64'(1) << order[g]);
      check_eq($sformatf("t2_rvalid%0d", g), 64'(ch_rvalid),
               (g > 0) ? (64'(1) << order[g-1]) : 64'd0);
      cyc();
      axi_bus.rvalid = 1'b0; axi_bus.rlast = 1'b0;
      mid();
      check_eq($sformatf("t2_arvalid%0d", g), 64'(axi_bus.arvalid), 64'd1);
      check_eq($sformatf("t2_arid%0d", g), 64'(axi_bus.arid), 64'(order[g]));
      check_eq($sformatf("t2_araddr%0d", g), 64'(axi_bus.araddr),
               64'h2000 + 64'(order[g]) * 64'h100);
      cyc();
    end
    ch_arvalid = '0;
    axi_bus.rvalid = 1'b1; axi_bus.rid = 8'd0; axi_bus.rlast = 1'b1;
    mid();
    check_eq("t2_idle", 64'(ch_arready), 64'd0);
    cyc();
    axi_bus.rvalid = 1'b0; axi_bus.rlast = 1'b0;
    check_eq("t2_err", 64'(err_id), 64'd0);

    // Channel 2 capped at 2 outstanding; channel 1 still served
    ch_arvalid = 4'b0100;
    mid(); check_eq("t3_grant2a", 64'(ch_arready), 64'h4); cyc();
    mid(); check_eq("t3_arid2a", 64'(axi_bus.arid), 64'd2); cyc();
    mid(); check_eq("t3_grant2b", 64'(ch_arready), 64'h4); cyc();
    mid(); cyc();
    mid(); check_eq("t3_full", 64'(ch_arready), 64'd0); cyc();
    ch_arvalid = 4'b0110;
    mid(); check_eq("t3_ch1", 64'(ch_arready), 64'h2); cyc();
    ch_arvalid = 4'b0100;
    mid(); check_eq("t3_arid1", 64'(axi_bus.arid), 64'd1); cyc();
    axi_bus.rvalid = 1'b1; axi_bus.rid = 8'd2; axi_bus.rlast = 1'b0; axi_bus.rdata = 16'h1234;
    mid();
    check_eq("t3_full_nolast", 64'(ch_arready), 64'd0);
    check_eq("t3_rvalid2", 64'(ch_rvalid), 64'h4);
    cyc();
    axi_bus.rlast = 1'b1;
    mid(); check_eq("t3_full_last", 64'(ch_arready), 64'd0); cyc();
    axi_bus.rvalid = 1'b0; axi_bus.rlast = 1'b0;
    mid(); check_eq("t3_grant2c", 64'(ch_arready), 64'h4); cyc();
    ch_arvalid = '0;
    mid(); check_eq("t3_arid2c", 64'(axi_bus.arid), 64'd2); cyc();

    // arready stalled, en dropped mid-wait
    axi_bus.arready = 1'b0;
    ch_arvalid = 4'b1000; ch_araddr[96 +: 32] = 32'hABCD_0000; ch_arlen[24 +: 8] = 8'h0F;
    mid(); check_eq("t4_grant3", 64'(ch_arready), 64'h8); cyc();
    ch_arvalid = 4'b0001;
    for (int w = 0; w < 5; w++) begin
      if (w == 2) en = 1'b0;
      mid();
      check_eq($sformatf("t4_arvalid%0d", w), 64'(axi_bus.arvalid), 64'd1);
      check_eq($sformatf("t4_araddr%0d", w), 64'(axi_bus.araddr), 64'hABCD_0000);
      check_eq($sformatf("t4_arlen%0d", w), 64'(axi_bus.arlen), 64'h0F);
      check_eq($sformatf("t4_arid%0d", w), 64'(axi_bus.arid), 64'd3);
      check_eq($sformatf("t4_noacc%0d", w), 64'(ch_arready), 64'd0);
      cyc();
    end
    axi_bus.arready = 1'b1;
    mid(); check_eq("t4_arvalid_hs", 64'(axi_bus.arvalid), 64'd1); cyc();
    mid();
    check_eq("t4_arvalid_done", 64'(axi_bus.arvalid), 64'd0);
    check_eq("t4_en_off", 64'(ch_arready), 64'd0);
    cyc();
    en = 1'b1;
    mid(); check_eq("t4_en_on", 64'(ch_arready), 64'h1); cyc();
    ch_arvalid = '0;
    mid(); check_eq("t4_arid0", 64'(axi_bus.arid), 64'd0); cyc();

    // R routing with backpressure, then unknown ID
    ch_rready = 4'b1101;
    axi_bus.rvalid = 1'b1; axi_bus.rid = 8'd1; axi_bus.rlast = 1'b0; axi_bus.rdata = 16'hBEEF;
    for (int s = 0; s < 2; s++) begin
      mid();
      check_eq($sformatf("t5_rready_stall%0d", s), 64'(axi_bus.rready), 64'd0);
      check_eq($sformatf("t5_rvalid%0d", s), 64'(ch_rvalid), 64'h2);
      check_eq($sformatf("t5_rdata%0d", s), 64'(ch_rdata), 64'hBEEF);
      check_eq($sformatf("t5_rlast%0d", s), 64'(ch_rlast), 64'd0);
      cyc();
    end
    ch_rready = 4'hF;
    mid(); check_eq("t5_rready_go", 64'(axi_bus.rready), 64'd1); cyc();
    ch_rready = 4'h0; axi_bus.rid = 8'd5;
    mid();
    check_eq("t5_unk_rready", 64'(axi_bus.rready), 64'd1);
    check_eq("t5_unk_rvalid", 64'(ch_rvalid), 64'd0);
    check_eq("t5_err_before", 64'(err_id), 64'd0);
    cyc();
    axi_bus.rvalid = 1'b0; ch_rready = 4'hF;
    mid(); check_eq("t5_err_set", 64'(err_id), 64'd1); cyc();
    cyc();
    mid(); check_eq("t5_err_held", 64'(err_id), 64'd1); cyc();

    // Same-cycle issue and completion on channel 0 (count 1 stays 1)
    ch_arvalid = 4'b0001;
    mid(); check_eq("t6_grant_a", 64'(ch_arready), 64'h1); cyc();
    axi_bus.rvalid = 1'b1; axi_bus.rid = 8'd0; axi_bus.rlast = 1'b1;
    mid(); check_eq("t6_arvalid", 64'(axi_bus.arvalid), 64'd1); cyc();
    axi_bus.rvalid = 1'b0; axi_bus.rlast = 1'b0;
    mid(); check_eq("t6_cnt1", 64'(ch_arready), 64'h1); cyc();
    mid(); cyc();
    mid(); check_eq("t6_full", 64'(ch_arready), 64'd0); cyc();
    ch_arvalid = '0;

    // Asynchronous reset during ISSUE, then rlast with nothing outstanding
    axi_bus.arready = 1'b0;
    ch_arvalid = 4'b1000;
    mid(); check_eq("t7_grant3", 64'(ch_arready), 64'h8); cyc();
    ch_arvalid = '0;
    mid();
    check_eq("t7_arvalid_pre", 64'(axi_bus.arvalid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("t7_arvalid_async", 64'(axi_bus.arvalid), 64'd0);
    check_eq("t7_araddr_async", 64'(axi_bus.araddr), 64'd0);
    check_eq("t7_arid_async", 64'(axi_bus.arid), 64'd0);
    cyc();
    rst = 1'b0;
    axi_bus.rvalid = 1'b1; axi_bus.rid = 8'd3; axi_bus.rlast = 1'b1;
    mid(); check_eq("t7_err_cleared", 64'(err_id), 64'd0); cyc();
    axi_bus.rvalid = 1'b0; axi_bus.rlast = 1'b0;
    mid(); check_eq("t7_err_underflow", 64'(err_id), 64'd1); cyc();
    ch_arvalid = 4'hF;
    mid(); check_eq("t7_rr_reset", 64'(ch_arready), 64'h1); cyc();
    ch_arvalid = '0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dc_axi_read_arbiter.md
Name: dc_axi_read_arbiter

Overview:
- Parametrised N-channel AXI read front-end for the display controller. It replaces the single fixed fetch-to-AXI path with a shared port serving NUM_CH fetching units, for example one per display layer.
- Read-address requests are arbitrated round-robin. Each granted burst is tagged with ARID equal to the channel index.
- Outstanding bursts are tracked per channel. Read data is routed back to the owning channel by RID.
- The block sits between the per-layer dc_fetching_unit instances and the external AXI read master port.

Parameters:
- NUM_CH, 4, number of requesting fetch channels (2..8).
- AXI_ARADDR_WIDTH, 32, address width.
- AXI_DATA_WIDTH, 16, read data width in bits (power of two, at least 8).
- MAX_OUTSTANDING, 2, maximum accepted-but-incomplete bursts per channel (1..7).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  arbitration enable; when low, no new channel request is accepted
- ch_arvalid  in  NUM_CH  per-channel burst request valid
- ch_arready  out  NUM_CH  per-channel request accept, one-hot or zero
- ch_araddr  in  NUM_CH*AXI_ARADDR_WIDTH  packed burst start addresses, channel i at slice i
- ch_arlen  in  NUM_CH*8  packed AXI burst lengths (beats-1)
- ch_rvalid  out  NUM_CH  per-channel read beat valid
- ch_rready  in  NUM_CH  per-channel read beat ready
- ch_rdata  out  AXI_DATA_WIDTH  read data, broadcast to all channels
- ch_rlast  out  1  last beat of burst, broadcast
- axi_arid  out  8  burst ID = granted channel index
- axi_araddr  out  AXI_ARADDR_WIDTH  burst address
- axi_arlen  out  8  burst length
- axi_arsize  out  3  constant log2(AXI_DATA_WIDTH/8)
- axi_arburst  out  2  constant 2'b01 (INCR)
- axi_arvalid  out  1  address valid
- axi_arready  in  1  address ready
- axi_rid  in  8  returned ID
- axi_rdata  in  AXI_DATA_WIDTH  returned data
- axi_rlast  in  1  last beat
- axi_rvalid  in  1  data valid
- axi_rready  out  1  data ready
- err_id  out  1  sticky: beat with RID >= NUM_CH, or rlast for a channel with zero outstanding

Behaviour:
- Reset (async, rst=1):
  - axi_arvalid=0, axi_arid=0, axi_araddr=0, axi_arlen=0, ch_arready=0, err_id=0.
  - All outstanding counters = 0.
  - rr_ptr = NUM_CH-1, so channel 0 has first priority.
  - FSM goes to IDLE.
  - Reset mid-burst abandons all tracking; no beats are replayed.
- AR FSM, two states: IDLE and ISSUE.
  - IDLE: when en=1, eligible(i) = ch_arvalid[i] && outstanding[i] < MAX_OUTSTANDING.
    - Grant the first eligible channel scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_CH.
    - In that same cycle, combinationally assert ch_arready[grant]=1.
    - Register axi_araddr, axi_arlen, axi_arid=grant; set axi_arvalid=1 next cycle; go to ISSUE.
    - No eligible channel, or en=0: stay in IDLE with ch_arready=0.
  - ISSUE: hold axi_arvalid and all payload stable until axi_arready=1.
    - On the handshake: axi_arvalid=0, outstanding[arid]++, rr_ptr<=arid, go to IDLE.
    - en=0 does not drop axi_arvalid in ISSUE (AXI stability rule).
  - Latency: channel accept at cycle N; axi_arvalid high at N+1. Maximum issue rate is one burst per 2 cycles.
- R routing (combinational, independent of en):
  - hit = axi_rid < NUM_CH.
  - ch_rvalid[i] = axi_rvalid && hit && axi_rid==i.
  - ch_rdata = axi_rdata; ch_rlast = axi_rlast.
  - axi_rready = hit ? ch_rready[axi_rid] : 1. Unknown-ID beats are drained and set err_id.
- Counters:
  - On an R handshake with axi_rlast=1 and hit: outstanding[rid]--. If the counter is 0, it stays 0 and err_id is set.
  - Same-cycle AR-handshake increment and rlast decrement on the same channel: counter unchanged.
  - Counter width is clog2(MAX_OUTSTANDING+1).
- A channel at MAX_OUTSTANDING is skipped by arbitration; other channels are served, so there is no head-of-line blocking.
- err_id clears only on reset.

Test Plan:
- Reset, then ch_arvalid=4'b0001, addr 0x1000, len 7, arready=1 -> ch_arready[0] pulses 1 cycle; next cycle axi_arvalid=1, araddr=0x1000, arlen=7, arid=0, arsize=1, arburst=1.
- All 4 channels request continuously, arready=1, rlast returned promptly -> grant order 0,1,2,3,0; one AR every 2 cycles.
- Channel 2 requests 3 bursts, no R data returned, MAX_OUTSTANDING=2 -> only 2 issued. Channel 1 request is still granted. After an rlast beat with rid=2, the third channel-2 burst issues.
- axi_arready held 0 for 5 cycles with en dropped mid-wait -> arvalid and payload stable throughout; issue completes when arready rises; no new grant while en=0.
- R beats: rid=1 with ch_rready[1]=0 for 2 cycles, then 1 -> axi_rready follows ch_rready[1]; only ch_rvalid[1] high. rid=5 (NUM_CH=4) -> axi_rready=1 and err_id set and held.
- Same-cycle AR handshake for channel 0 and rlast for channel 0 with outstanding=1 -> counter stays 1. Assert rst during ISSUE -> axi_arvalid=0 immediately (async).
